sar_search_ctrl: RTL



---
 rtl/sar_search_ctrl_pkg.sv | 26 ++
 rtl/sar_resp_decode.sv | 30 +++
 rtl/sar_search_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_pkg.sv
// ============================================================================
//  Module   : sar_search_ctrl_pkg
//  Purpose  : Shared state and comparator-response encodings for the SAR
//             search controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sar_search_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_LT  = 2'd0;
    localparam resp_t RESP_GT  = 2'd1;
    localparam resp_t RESP_EQ  = 2'd2;
    localparam resp_t RESP_BAD = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sar_resp_decode.sv
// ============================================================================
//  Module   : sar_resp_decode
//  Purpose  : Maps the comparator's one-hot {lt,gt,eq} flags to a response code.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sar_resp_decode
    import sar_search_ctrl_pkg::*;
(
    input  logic  lt_i,
    input  logic  gt_i,
    input  logic  eq_i,
    output resp_t resp_o
);

    // Anything other than exactly one asserted flag is an illegal response.
    always_comb begin
        resp_o = RESP_BAD;
        case ({lt_i, gt_i, eq_i})
            3'b100:  resp_o = RESP_LT;
            3'b010:  resp_o = RESP_GT;
            3'b001:  resp_o = RESP_EQ;
            default: resp_o = RESP_BAD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sar_search_ctrl.sv
// ============================================================================
//  Module   : sar_search_ctrl
//  Purpose  : Binary-search controller that drives a probe into a magnitude
//             comparator and locates the comparator's hidden operand.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    count
);

    localparam logic [WIDTH:0]  C_ONE     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]  C_HI_INIT = {1'b0, {WIDTH{1'b1}}};
    localparam logic [CW-1:0]   C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH:0]   mid, mid_p1, mid_m1;
    logic [WIDTH-1:0] probe_q, probe_d, result_q, result_d;
    logic             found_q, found_d, err_q, err_d;
    logic [CW-1:0]    count_q, count_d;
    resp_t            resp;

    // One guard bit keeps lo+hi and mid+1 from wrapping at the top of range.
    assign mid    = (lo_q + hi_q) >> 1;
    assign mid_p1 = mid + C_ONE;
    assign mid_m1 = mid - C_ONE;

    sar_resp_decode u_decode (
        .lt_i   (lt),
        .gt_i   (gt),
        .eq_i   (eq),
        .resp_o (resp)
    );

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = C_HI_INIT;
                    count_d = '0;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                count_d = count_q + C_CNT_ONE;
                probe_d = mid[WIDTH-1:0];
                case (resp)
                    RESP_EQ: begin
                        found_d  = 1'b1;
                        result_d = mid[WIDTH-1:0];
                        state_d  = FINISH;
                    end
                    RESP_LT: begin
                        lo_d = mid_p1;
                        if (mid_p1 > hi_q) begin
                            state_d = FINISH;
                        end
                    end
                    RESP_GT: begin
                        // mid==0 would underflow hi; the range is exhausted anyway.
                        if (mid == '0) begin
                            state_d = FINISH;
                        end else begin
                            hi_d = mid_m1;
                            if (lo_q > mid_m1) begin
                                state_d = FINISH;
                            end
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        found_d = 1'b0;
                        state_d = FINISH;
                    end
                endcase
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= C_HI_INIT;
            probe_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign busy   = (state_q == PROBE);
    assign done   = (state_q == FINISH);
    assign probe  = busy ? mid[WIDTH-1:0] : probe_q;
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;
    assign count  = count_q;

endmodule

`default_nettype wire
